// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier with MIPS-style LO/HI result halves.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] multiplicand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lowerProd,
  output logic [WIDTH-1:0] upperProd
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     count;
  logic              sign;

  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              sign_in;
  logic [PW-1:0]     acc_nxt;
  logic [PW-1:0]     result;
  logic              last;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a   = multiplier;
    mag_b   = multiplicand;
    sign_in = 1'b0;
    if (is_signed) begin
      if (multiplier[WIDTH-1])
        mag_a = -multiplier;
      if (multiplicand[WIDTH-1])
        mag_b = -multiplicand;
      sign_in = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
    end
  end

  always_comb begin
    acc_nxt = acc;
    if (mplier[0])
      acc_nxt = acc + mcand;
    result = sign ? -acc_nxt : acc_nxt;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last = (count == CW'(WIDTH - 1)) ||
           (mplier[WIDTH-1:1] == '0);
`else
    last = (count == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      lowerProd <= '0;
      upperProd <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      sign      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_b};
            mplier <= mag_a;
            sign   <= sign_in;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            lowerProd <= result[WIDTH-1:0];
            upperProd <= result[PW-1:WIDTH];
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle model, directed cases, random traffic.
// Honors SEQ_MULT_EARLY_TERM_EN for expected latency.
module tb_seq_multiplier;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] multiplier = '0;
  logic [W-1:0] multiplicand = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] lowerProd;
  logic [W-1:0] upperProd;

  int n_checks = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .done         (done),
    .lowerProd    (lowerProd),
    .upperProd    (upperProd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return (2*W)'(pa * pb);
  endfunction

  // Number of RUN cycles (busy-high cycles) for a request.
  function automatic int steps(input logic [W-1:0] a,
                               input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint m;
    int h;
    m = (s && a[W-1]) ? -longint'($signed(a))
                      : longint'(a);
    h = -1;
    for (int i = 0; i < W + 1; i++)
      if (m[i]) h = i;
    return (h < 1) ? 1 : h + 1;
`else
    return W + (0 * int'(a)) + (0 * int'(s));
`endif
  endfunction

  // Behavioural model: remaining busy cycles plus held result.
  int             m_left = 0;
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;

  initial begin : compare
    forever begin
      @(posedge clk);
      if (reset) begin
        m_left = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_prod = '0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = m_pend;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (start) begin
        m_pend = ref_prod(multiplier, multiplicand, is_signed);
        m_left = steps(multiplier, is_signed);
        m_busy = 1'b1;
      end
      @(negedge clk);
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("prod", 64'({upperProd, lowerProd}), 64'(m_prod));
    end
  end

  logic [2*W-1:0] last_lit = '0;

  // inject > 0: pulse start with new operands at that RUN step.
  task automatic mul(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic s,
                     input logic [2*W-1:0] lit,
                     input int inject,
                     input string name);
    int edges;
    int busyc;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    multiplier = a;
    multiplicand = b;
    is_signed = s;
    @(negedge clk);
    start = 1'b0;
    multiplier = W'($urandom);
    multiplicand = W'($urandom);
    is_signed = 1'($urandom);
    check({name, "_hold"},
          64'({upperProd, lowerProd}), 64'(last_lit));
    edges = 1;
    busyc = busy ? 1 : 0;
    while (!done && edges < 200) begin
      if (inject > 0 && edges == inject) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      edges++;
      if (busy) busyc++;
    end
    check({name, "_lat"}, 64'(edges), 64'(steps(a, s) + 1));
    check({name, "_busy"}, 64'(busyc), 64'(steps(a, s)));
    check({name, "_val"},
          64'({upperProd, lowerProd}), 64'(lit));
    last_lit = lit;
  endtask

  initial begin : stim
    int pulses;
    logic [W-1:0] pick [5];
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_prod", 64'({upperProd, lowerProd}), 64'(0));
    reset = 1'b0;

    mul(16'h1234, 16'h5678, 1'b0, 32'h06260060, 0, "u1234");
    mul(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, "uffff");
    mul(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 0, "sm1x2");
    mul(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 0, "uffx2");
    mul(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, "smin2");
    mul(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 0, "sminx1");
    mul(16'h0000, 16'h8000, 1'b1, 32'h00000000, 0, "szero");
    mul(16'h0003, 16'h1234, 1'b0, 32'h0000369C, 0, "u3");
    mul(16'h0000, 16'h1234, 1'b0, 32'h00000000, 0, "uz");
    mul(16'h00FF, 16'hFF00, 1'b1, 32'hFFFF0100, 0, "smix");
    mul(16'h0102, 16'h0304, 1'b0, 32'h00030A08, 5, "ign");
    mul(16'h4000, 16'h0004, 1'b0, 32'h00010000, 0, "after");

    // Abort mid-RUN with reset.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    multiplier = 16'hFFFF;
    multiplicand = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_prod", 64'({upperProd, lowerProd}), 64'(0));
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_nodone", 64'(pulses), 64'(0));
    last_lit = '0;
    mul(16'h0010, 16'h0010, 1'b0, 32'h00000100, 0, "fresh");

    // Reset and start on the same edge.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_start_nodone", 64'(pulses), 64'(0));

    // Random traffic against the model.
    pick[0] = 16'h0000;
    pick[1] = 16'h8000;
    pick[2] = 16'hFFFF;
    pick[3] = 16'h0001;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pick[4] = W'($urandom);
      start = ($urandom_range(0, 3) == 0);
      is_signed = 1'($urandom);
      multiplier = ($urandom_range(0, 3) == 0)
                   ? pick[$urandom_range(0, 4)] : W'($urandom);
      pick[4] = W'($urandom);
      multiplicand = ($urandom_range(0, 3) == 0)
                     ? pick[$urandom_range(0, 4)] : W'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
